// File: rtl/fnd_display_controller_pkg.sv
// Shared definitions for the FND display controller: segment patterns, converter
// state codes and the small combinational helpers used by the datapath.
package fnd_display_controller_pkg;

  localparam int unsigned BIN_W = 12;
  localparam int unsigned BCD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } conv_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit left off (1) in every pattern.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] work);
    logic [BCD_W-1:0] adj;
    adj = work;
    for (int i = 0; i < 4; i++) begin
      if (work[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/fnd_display_controller_bcd.sv
// Serial binary-to-BCD converter (shift-add-3), one input bit per clock.
// done is high for exactly the single LOAD cycle, when bcd holds the result.
module fnd_display_controller_bcd
  import fnd_display_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(BIN_W);

  conv_state_e      r_state;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // Top work bit is shifted out; a 12-bit input never reaches it.
  logic [BCD_W-2:0] w_adj;
  assign w_adj = (BCD_W-1)'(bcd_add3(r_work));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift <= bin;
            r_work  <= '0;
            r_cnt   <= '0;
            r_state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          r_work  <= {w_adj, r_shift[BIN_W-1]};
          r_shift <= {r_shift[BIN_W-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state <= ST_LOAD;
            r_done  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd  = r_work;
  assign done = r_done;

endmodule

// File: rtl/fnd_display_controller.sv
// 4-digit common-anode FND controller: valid/ready value intake, serial BCD
// conversion, display latch and free-running digit scan with leading-zero blanking.
module fnd_display_controller
  import fnd_display_controller_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [BIN_W-1:0] value,
  input  logic             value_valid,
  output logic             ready,
  output logic             busy,
  input  logic             blank_lz,
  input  logic [3:0]       dp_en,
  output logic [7:0]       seg_out,
  output logic [3:0]       an_out
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic             r_ready;
  logic             r_busy;
  logic [BCD_W-1:0] r_disp;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;

  logic             w_start;
  logic [BCD_W-1:0] w_bcd;
  logic             w_done;
  logic [3:0]       w_nib;
  logic [3:0]       w_zero;
  logic             w_blank;
  logic [7:0]       w_seg;

  assign w_start = value_valid & r_ready;

  fnd_display_controller_bcd u_bcd (
    .clk     (clk),
    .reset_p (reset_p),
    .start   (w_start),
    .bin     (value),
    .bcd     (w_bcd),
    .done    (w_done)
  );

  // Handshake and display latch; display only changes on a completed conversion.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_disp  <= '0;
    end else if (w_done) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_disp  <= w_bcd;
    end else if (w_start) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end
  end

  // Free-running digit scan, independent of the converter.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Digit k blanks only when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    w_nib = r_disp[{r_idx, 2'b00} +: 4];
    for (int k = 0; k < 4; k++) begin
      w_zero[k] = (r_disp[k*4 +: 4] == 4'd0);
    end
    case (r_idx)
      2'd3:    w_blank = blank_lz & w_zero[3];
      2'd2:    w_blank = blank_lz & (&w_zero[3:2]);
      2'd1:    w_blank = blank_lz & (&w_zero[3:1]);
      default: w_blank = 1'b0;
    endcase
    w_seg    = w_blank ? SEG_BLANK : seg_decode(w_nib);
    w_seg[7] = ~dp_en[r_idx];
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_seg <= SEG_BLANK;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg;
      r_an  <= ~(4'b0001 << r_idx);
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign seg_out = r_seg;
  assign an_out  = r_an;

endmodule

// File: tb/tb_fnd_display_controller.sv
// Directed bench for fnd_display_controller with a scoreboard of expected digit
// segments derived arithmetically from the offered value.
module tb_fnd_display_controller;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk         = 1'b0;
  logic        reset_p     = 1'b1;
  logic [11:0] value       = '0;
  logic        value_valid = 1'b0;
  logic        ready;
  logic        busy;
  logic        blank_lz    = 1'b0;
  logic [3:0]  dp_en       = 4'b0000;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fnd_display_controller #(.SCAN_DIV(SCAN_DIV)) u_dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .value       (value),
    .value_valid (value_valid),
    .ready       (ready),
    .busy        (busy),
    .blank_lz    (blank_lz),
    .dp_en       (dp_en),
    .seg_out     (seg_out),
    .an_out      (an_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int v, input logic blz, input logic [3:0] dp, input int d);
    int         dig[4];
    logic [7:0] p;
    logic       blank;
    dig[0] = v % 10;
    dig[1] = (v / 10) % 10;
    dig[2] = (v / 100) % 10;
    dig[3] = (v / 1000) % 10;
    case (dig[d])
      0:       p = 8'hC0;
      1:       p = 8'hF9;
      2:       p = 8'hA4;
      3:       p = 8'hB0;
      4:       p = 8'h99;
      5:       p = 8'h92;
      6:       p = 8'h82;
      7:       p = 8'hF8;
      8:       p = 8'h80;
      9:       p = 8'h90;
      default: p = 8'hFF;
    endcase
    blank = blz && (d > 0);
    for (int k = d; k < 4; k++) if (dig[k] != 0) blank = 1'b0;
    if (blank) p = 8'hFF;
    p[7] = ~dp[d];
    return p;
  endfunction

  task automatic push_exp(input int v);
    for (int d = 0; d < 4; d++) exp_q.push_back(exp_seg(v, blank_lz, dp_en, d));
  endtask

  task automatic wait_ready(input string tag, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (ready !== 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 64) chk({tag, "_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic send(input int v, input string tag);
    int cyc;
    @(negedge clk);
    value       = 12'(v);
    value_valid = 1'b1;
    @(posedge clk);
    #1 value_valid = 1'b0;
    push_exp(v);
    chk({tag, "_busy"}, 16'(busy), 16'd1);
    wait_ready(tag, cyc);
    chk({tag, "_ready_low"}, 16'(cyc), 16'd13);
  endtask

  // Align to a fresh digit-0 slot, then check each digit's anode, segments and hold time.
  task automatic check_frame(input string tag);
    logic [3:0] prev;
    logic [3:0] a0;
    logic [3:0] ea;
    logic [7:0] s0;
    logic [7:0] e;
    logic       hold;
    int         guard;
    @(negedge clk);
    prev  = an_out;
    guard = 0;
    @(negedge clk);
    while (!(an_out === 4'b1110 && prev !== 4'b1110) && guard < 64) begin
      prev = an_out;
      guard++;
      @(negedge clk);
    end
    if (guard >= 64) chk({tag, "_align_timeout"}, 16'd0, 16'd1);
    for (int d = 0; d < 4; d++) begin
      e = 8'hFF;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else chk({tag, "_queue_empty"}, 16'd0, 16'd1);
      ea    = 4'b1111;
      ea[d] = 1'b0;
      a0 = an_out;
      s0 = seg_out;
      chk($sformatf("%s_d%0d_an", tag, d), 16'(an_out), 16'(ea));
      chk($sformatf("%s_d%0d_seg", tag, d), 16'(seg_out), 16'(e));
      hold = 1'b1;
      repeat (SCAN_DIV - 1) begin
        @(negedge clk);
        if (an_out !== a0 || seg_out !== s0) hold = 1'b0;
      end
      chk($sformatf("%s_d%0d_hold", tag, d), 16'(hold), 16'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int di;

    // Reset state while reset_p is held
    repeat (3) @(negedge clk);
    chk("rst_seg", 16'(seg_out), 16'hFF);
    chk("rst_an", 16'(an_out), 16'hF);
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    reset_p = 1'b0;
    @(negedge clk);
    chk("first_an", 16'(an_out), 16'b1110);
    chk("first_seg", 16'(seg_out), 16'hC0);

    // Plain conversion
    send(1234, "v1234");
    check_frame("v1234");

    // Leading-zero blanking: interior zero shown, all-zero upper digits blanked
    blank_lz = 1'b1;
    send(4095, "v4095");
    check_frame("v4095");
    send(0, "v0");
    check_frame("v0");

    // Decimal point on a non-blanked zero digit
    blank_lz = 1'b0;
    dp_en    = 4'b0010;
    send(7, "v7");
    check_frame("v7");

    // Asynchronous reset mid-run
    dp_en = 4'b0000;
    @(negedge clk);
    #2 reset_p = 1'b1;
    #1;
    chk("midrst_seg", 16'(seg_out), 16'hFF);
    chk("midrst_an", 16'(an_out), 16'hF);
    chk("midrst_ready", 16'(ready), 16'd1);
    @(negedge clk);
    reset_p = 1'b0;
    push_exp(0);
    check_frame("midrst");

    // Back-to-back: value_valid held, value changed while busy
    @(negedge clk);
    value       = 12'd100;
    value_valid = 1'b1;
    @(posedge clk);
    #1 value = 12'd200;
    chk("b2b_busy", 16'(busy), 16'd1);
    wait_ready("b2b", cyc);
    chk("b2b_ready_low", 16'(cyc), 16'd13);
    @(posedge clk);
    #1 value_valid = 1'b0;
    chk("b2b_accept", 16'(busy), 16'd1);
    @(negedge clk);
    @(negedge clk);
    di = -1;
    for (int d = 0; d < 4; d++) if (an_out === ~(4'b0001 << d)) di = d;
    if (di < 0) chk("b2b_an_onehot", 16'(an_out), 16'b1110);
    else chk("b2b_first_value", 16'(seg_out), 16'(exp_seg(100, 1'b0, 4'b0000, di)));
    push_exp(200);
    wait_ready("b2b2", cyc);
    chk("b2b2_ready_low", 16'(cyc), 16'd11);
    check_frame("b2b200");

    // Reset in the middle of a conversion, then a clean conversion
    @(negedge clk);
    value       = 12'd999;
    value_valid = 1'b1;
    @(posedge clk);
    #1 value_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset_p = 1'b1;
    #1;
    chk("cvrst_ready", 16'(ready), 16'd1);
    chk("cvrst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    reset_p = 1'b0;
    push_exp(0);
    check_frame("cvrst");
    send(321, "v321");
    check_frame("v321");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
